// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: response tags, request word
// layout {addr, wdata, we} and sticky error bit positions.
package mem_port_arbiter_pkg;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  localparam int ERR_IOVF = 0;
  localparam int ERR_DOVF = 1;
  localparam int ERR_SPUR = 2;
  localparam int ERR_W    = 3;

  // Request word is {addr[aw], wdata[DATA_W], we[WE_W]}, addr in the MSBs.
  function automatic int req_width(input int aw);
    return aw + DATA_W + WE_W;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sync_fifo.sv
// Synchronous FIFO with combinational head; a push while full is accepted
// only when the same cycle pops. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == {(PW+1){1'b0}});
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    mem_d[wr_ptr_q] = do_push ? wdata : mem_q[wr_ptr_q];
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch (I) and load/store (D):
// per-port request FIFOs, registered in-order issue, tag FIFO for response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int RR      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_oe,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ready,
  input  logic          d_oe,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_we,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          m_oe,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_we,
  input  logic [31:0]   m_rdata,
  input  logic          m_ready,
  output logic [2:0]    err
);

  localparam int REQ_W = req_width(AW);
  localparam int OW    = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] OUT_MAX = MAX_OUT[OW-1:0];
  localparam logic [OW-1:0] OUT_ONE = {{(OW-1){1'b0}}, 1'b1};

  logic [REQ_W-1:0] i_word, d_word, i_head, d_head, head;
  logic             i_full, i_empty, d_full, d_empty;
  logic             tag_full, tag_empty, tag_head, tag_in;
  logic             i_pop, d_pop, issue, can_issue, grant_d, resp_ok, spur;

  logic             m_oe_q, m_oe_d;
  logic [AW-1:0]    m_addr_q, m_addr_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic [3:0]       m_we_q, m_we_d;
  logic [OW-1:0]    out_q, out_d;
  logic             last_grant_q, last_grant_d;
  logic [ERR_W-1:0] err_q, err_d;

  assign i_word = {i_addr, {DATA_W{1'b0}}, {WE_W{1'b0}}};
  assign d_word = {d_addr, d_wdata, d_we};

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_i_fifo (
    .clk(clk), .rst(rst), .push(i_oe), .wdata(i_word), .pop(i_pop),
    .rdata(i_head), .full(i_full), .empty(i_empty)
  );

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_d_fifo (
    .clk(clk), .rst(rst), .push(d_oe), .wdata(d_word), .pop(d_pop),
    .rdata(d_head), .full(d_full), .empty(d_empty)
  );

  sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk(clk), .rst(rst), .push(issue), .wdata(tag_in), .pop(resp_ok),
    .rdata(tag_head), .full(tag_full), .empty(tag_empty)
  );

  // Arbitration, issue, outstanding tracking and sticky errors.
  always_comb begin
    resp_ok   = m_ready & ~tag_empty;
    spur      = m_ready & tag_empty;
    can_issue = ((out_q < OUT_MAX) & ~tag_full) | resp_ok;
    if (!i_empty && !d_empty) begin
      grant_d = (RR != 32'sd0) ? (last_grant_q == TAG_I) : 1'b1;
    end else begin
      grant_d = ~d_empty;
    end
    issue  = can_issue & ~(i_empty & d_empty);
    i_pop  = issue & ~grant_d;
    d_pop  = issue & grant_d;
    tag_in = grant_d ? TAG_D : TAG_I;
    head   = grant_d ? d_head : i_head;

    m_oe_d       = issue;
    m_addr_d     = issue ? head[REQ_W-1 -: AW] : m_addr_q;
    m_wdata_d    = issue ? head[WE_W +: DATA_W] : m_wdata_q;
    m_we_d       = issue ? head[WE_W-1:0] : {WE_W{1'b0}};
    last_grant_d = issue ? tag_in : last_grant_q;

    case ({issue, resp_ok})
      2'b10:   out_d = out_q + OUT_ONE;
      2'b01:   out_d = out_q - OUT_ONE;
      default: out_d = out_q;
    endcase

    err_d           = err_q;
    err_d[ERR_IOVF] = err_q[ERR_IOVF] | (i_oe & i_full & ~i_pop);
    err_d[ERR_DOVF] = err_q[ERR_DOVF] | (d_oe & d_full & ~d_pop);
    err_d[ERR_SPUR] = err_q[ERR_SPUR] | spur;
  end

  // Downstream request, grant history, outstanding count and error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_oe_q       <= 1'b0;
      m_addr_q     <= {AW{1'b0}};
      m_wdata_q    <= {DATA_W{1'b0}};
      m_we_q       <= {WE_W{1'b0}};
      out_q        <= {OW{1'b0}};
      last_grant_q <= TAG_I;
      err_q        <= {ERR_W{1'b0}};
    end else begin
      m_oe_q       <= m_oe_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_we_q       <= m_we_d;
      out_q        <= out_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign m_oe    = m_oe_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_we    = m_we_q;
  assign err     = err_q;

  // Responses follow the tag at the head; a response with no tag is dropped.
  assign i_ready = resp_ok & (tag_head == TAG_I);
  assign d_ready = resp_ok & (tag_head == TAG_D);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule
